// File: rtl/sort_4x8b_bubble_seq_ctrl_if.sv
// Producer/consumer handshake bundle for the sequential bubble-sort engine.
// The master modport is the environment side (producer + consumer); the slave
// modport is the sort engine.
interface sort_4x8b_bubble_seq_ctrl_if #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
);
   localparam int unsigned CW = $clog2(N * (N - 1) / 2 + 1);

   logic              in_valid;
   logic              in_ready;
   logic [N*W-1:0]    in_data;
   logic              out_valid;
   logic              out_ready;
   logic [N*W-1:0]    out_data;
   logic              busy;
   logic [CW-1:0]     swap_cnt;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy, swap_cnt
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy, swap_cnt
   );
endinterface

// File: rtl/sort_4x8b_bubble_seq_ctrl.sv
// Sequential bubble-sort engine: one compare-exchange unit walks a registered
// N-lane vector, one adjacent pair per clock, lane 0 ends up smallest.
// Optional feature macro: SORT_EARLY_EXIT_EN (stop after the first pass that
// performs no swap). Without it every vector takes the full (N-1)^2 compares.
module sort_4x8b_bubble_seq_ctrl #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   sort_4x8b_bubble_seq_ctrl_if.slave  bus
);
   localparam int unsigned CW = $clog2(N * (N - 1) / 2 + 1);
   localparam int unsigned IW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SORT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            in_ready_q, out_valid_q, busy_q;
   logic            in_ready_next, out_valid_next, busy_next;

   logic [W-1:0]    lane [N];
   logic [IW-1:0]   idx;
   logic [IW-1:0]   pass;
   logic [CW-1:0]   swap_cnt;

   logic            accept;
   logic            do_swap;
   logic            last_cmp;
   logic            early_exit;
   logic [W-1:0]    lane_lo;
   logic [W-1:0]    lane_hi;

   assign accept   = bus.in_valid & in_ready_q;
   assign lane_lo  = lane[idx];
   assign lane_hi  = lane[idx + IW'(1)];
   // Strict compare keeps equal lanes in place, so the sort is stable.
   assign do_swap  = (state == SORT) && (lane_lo > lane_hi);
   assign last_cmp = (pass == LAST) && (idx == LAST);

`ifdef SORT_EARLY_EXIT_EN
   logic pass_swap_q;
   logic pass_swap;

   // Swap seen so far in the current pass, including this cycle's compare.
   assign pass_swap  = ((idx == '0) ? 1'b0 : pass_swap_q) | do_swap;
   assign early_exit = (state == SORT) && (idx == LAST) && !pass_swap;

   // Per-pass swap flag, restarted at the first compare of each pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              pass_swap_q <= 1'b0;
      else if (accept)         pass_swap_q <= 1'b0;
      else if (state == SORT)  pass_swap_q <= pass_swap;
   end
`else
   assign early_exit = 1'b0;
`endif

   // State and registered handshake flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_next;
         in_ready_q  <= in_ready_next;
         out_valid_q <= out_valid_next;
         busy_q      <= busy_next;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)                   state_next = SORT;
         SORT:    if (last_cmp || early_exit)   state_next = DONE;
         DONE:    if (bus.out_ready)            state_next = IDLE;
         default:                               state_next = IDLE;
      endcase
   end

   // Flag values for the state being entered, so the flags are flop outputs.
   always_comb begin
      in_ready_next  = 1'b0;
      out_valid_next = 1'b0;
      busy_next      = 1'b0;
      case (state_next)
         IDLE:    in_ready_next  = 1'b1;
         SORT:    busy_next      = 1'b1;
         DONE:    out_valid_next = 1'b1;
         default: in_ready_next  = 1'b1;
      endcase
   end

   // Lane registers, pair pointer, pass counter and swap counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) lane[i] <= '0;
         idx      <= '0;
         pass     <= '0;
         swap_cnt <= '0;
      end else if (accept) begin
         for (int i = 0; i < N; i++) lane[i] <= bus.in_data[i*W +: W];
         idx      <= '0;
         pass     <= '0;
         swap_cnt <= '0;
      end else if (state == SORT) begin
         if (do_swap) begin
            lane[idx]           <= lane_hi;
            lane[idx + IW'(1)]  <= lane_lo;
            swap_cnt            <= swap_cnt + CW'(1);
         end
         if (idx == LAST) begin
            idx  <= '0;
            pass <= pass + IW'(1);
         end else begin
            idx  <= idx + IW'(1);
         end
      end
   end

   // Flatten lane registers onto the output bus.
   always_comb begin
      bus.out_data = '0;
      for (int i = 0; i < N; i++) bus.out_data[i*W +: W] = lane[i];
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.swap_cnt  = swap_cnt;
endmodule
